// File: rtl/if_ctrl.sv
// Instruction-fetch controller: sequences PC and ROM accesses, handles stall/flush/branch redirects.
// Optional skid buffer (macro IF_SKID_EN) keeps a word returned during a stall so it is never re-read.
module if_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h00000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target_i,
   output logic        rom_ce,
   output logic [31:0] rom_addr,
   input  logic        rom_rdy,
   input  logic [31:0] rom_data,
   output logic        inst_valid,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc,
   output logic [1:0]  fsm_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   localparam logic CHIP_ENABLE  = 1'b1;
   localparam logic CHIP_DISABLE = 1'b0;

   logic [1:0]  state;
   logic        pend_valid;
   logic [31:0] pend_target;
   logic [31:0] flush_pc;
   logic [31:0] branch_pc;
   logic [31:0] seq_next;
   logic [31:0] next_pc;
`ifdef IF_SKID_EN
   logic [31:0] skid_data;
   logic [31:0] skid_pc;
`endif

   // ROM handshake: while rom_ce is high the ROM presents rom_data for rom_addr
   // and raises rom_rdy in the same cycle; a word is consumed only on an edge
   // where rom_rdy=1 and the fetch is not stalled or flushed.
   assign flush_pc  = {new_pc_i[31:2], 2'b00};
   assign branch_pc = {branch_target_i[31:2], 2'b00};
   assign fsm_state = state;

   always_comb begin
      seq_next = pend_valid ? pend_target : rom_addr + 32'd4;
      next_pc  = branch_flag_i ? branch_pc : seq_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         rom_ce      <= CHIP_DISABLE;
         rom_addr    <= RESET_PC;
         inst_valid  <= 1'b0;
         inst_o      <= 32'd0;
         inst_pc     <= 32'd0;
         pend_valid  <= 1'b0;
         pend_target <= 32'd0;
`ifdef IF_SKID_EN
         skid_data   <= 32'd0;
         skid_pc     <= 32'd0;
`endif
      end else if (flush_i) begin
         rom_addr   <= flush_pc;
         inst_valid <= 1'b0;
         pend_valid <= 1'b0;
         rom_ce     <= CHIP_ENABLE;
         state      <= S_REQ;
      end else begin
         case (state)
            S_IDLE: begin
               rom_ce <= CHIP_ENABLE;
               state  <= S_REQ;
            end
            S_REQ: begin
               if (!stall_i) begin
                  if (rom_rdy) begin
                     inst_o     <= rom_data;
                     inst_pc    <= rom_addr;
                     inst_valid <= 1'b1;
                     rom_addr   <= next_pc;
                     // A taken branch supersedes any older pending target.
                     pend_valid <= 1'b0;
                  end else begin
                     inst_valid <= 1'b0;
                     if (branch_flag_i) begin
                        pend_target <= branch_pc;
                        pend_valid  <= 1'b1;
                     end
                  end
               end
`ifdef IF_SKID_EN
               else if (rom_rdy) begin
                  skid_data  <= rom_data;
                  skid_pc    <= rom_addr;
                  rom_addr   <= seq_next;
                  pend_valid <= 1'b0;
                  rom_ce     <= CHIP_DISABLE;
                  state      <= S_HOLD;
               end
`endif
            end
`ifdef IF_SKID_EN
            S_HOLD: begin
               if (!stall_i) begin
                  inst_o     <= skid_data;
                  inst_pc    <= skid_pc;
                  inst_valid <= 1'b1;
                  rom_ce     <= CHIP_ENABLE;
                  state      <= S_REQ;
                  // The buffered word is the delay slot; the branch redirects the unfetched next address.
                  if (branch_flag_i) rom_addr <= branch_pc;
               end
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_if_ctrl.sv
// Self-checking bench for if_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_if_ctrl;

   localparam logic [31:0] RESET_PC = 32'h00000000;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   logic        rom_ce;
   logic [31:0] rom_addr;
   logic        rom_rdy;
   logic [31:0] rom_data;
   logic        inst_valid;
   logic [31:0] inst_o;
   logic [31:0] inst_pc;
   logic [1:0]  fsm_state;

   int errors = 0;
   int checks = 0;

   // Model state: fetch pointer, delivered instruction, pending branch target (0 or 1 entries).
   logic        m_on;
   logic        m_ce;
   logic [31:0] m_addr;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_pc;
   logic [31:0] exp_q[$];
`ifdef IF_SKID_EN
   logic        m_hold;
   logic [31:0] m_hdata;
   logic [31:0] m_hpc;
`endif

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h5A3C96E1;
   endfunction

   assign rom_data = rom_word(rom_addr);

   if_ctrl #(.RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
      .branch_flag_i(branch_flag_i), .branch_target_i(branch_target_i),
      .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_rdy(rom_rdy), .rom_data(rom_data),
      .inst_valid(inst_valid), .inst_o(inst_o), .inst_pc(inst_pc), .fsm_state(fsm_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall_i = 1'b0; flush_i = 1'b0; new_pc_i = 32'd0;
      branch_flag_i = 1'b0; branch_target_i = 32'd0; rom_rdy = 1'b1;
   endtask

   // Leaves rst released just after an edge, so the next tick is E0.
   task automatic restart();
      rst = 1'b0;
      idle_inputs();
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      idle_inputs();
      tick();
      tick();
      checks++;
      if (rom_ce !== 1'b0 || rom_addr !== RESET_PC || inst_valid !== 1'b0 || inst_o !== 32'd0 || inst_pc !== 32'd0) begin
         errors++;
         $display("FAIL reset: ce=%b addr=%h valid=%b inst=%h pc=%h expected 0/%h/0/0/0", rom_ce, rom_addr, inst_valid, inst_o, inst_pc, RESET_PC);
      end
   endtask

   task automatic test_sequential();
      restart();
      tick();
      checks++;
      if (rom_ce !== 1'b1 || rom_addr !== RESET_PC || inst_valid !== 1'b0) begin
         errors++;
         $display("FAIL first_fetch_e0: ce=%b addr=%h valid=%b expected 1/%h/0", rom_ce, rom_addr, inst_valid, RESET_PC);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (inst_valid !== 1'b1 || inst_pc !== 32'(i * 4) || inst_o !== rom_word(32'(i * 4)) || rom_addr !== 32'(i * 4 + 4)) begin
            errors++;
            $display("FAIL seq_%0d: valid=%b pc=%h inst=%h addr=%h expected 1/%h/%h/%h", i, inst_valid, inst_pc, inst_o, rom_addr,
                     32'(i * 4), rom_word(32'(i * 4)), 32'(i * 4 + 4));
         end
      end
   endtask

   task automatic test_wait_states();
      restart();
      repeat (3) tick();
      rom_rdy = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (inst_valid !== 1'b0 || rom_addr !== 32'h8 || rom_ce !== 1'b1) begin
            errors++;
            $display("FAIL wait_bubble_%0d: valid=%b addr=%h ce=%b expected 0/00000008/1", i, inst_valid, rom_addr, rom_ce);
         end
      end
      rom_rdy = 1'b1;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || inst_o !== rom_word(32'h8)) begin
         errors++;
         $display("FAIL wait_resume: valid=%b pc=%h inst=%h expected 1/00000008/%h", inst_valid, inst_pc, inst_o, rom_word(32'h8));
      end
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'hC) begin
         errors++;
         $display("FAIL wait_next: valid=%b pc=%h expected 1/0000000c", inst_valid, inst_pc);
      end
   endtask

   task automatic test_branch_pending();
      restart();
      repeat (5) tick();
      rom_rdy = 1'b0; branch_flag_i = 1'b1; branch_target_i = 32'h100;
      tick();
      checks++;
      if (inst_valid !== 1'b0 || rom_addr !== 32'h10) begin
         errors++;
         $display("FAIL branch_wait: valid=%b addr=%h expected 0/00000010", inst_valid, rom_addr);
      end
      rom_rdy = 1'b1; branch_flag_i = 1'b0;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || rom_addr !== 32'h100) begin
         errors++;
         $display("FAIL branch_delay_slot: valid=%b pc=%h addr=%h expected 1/00000010/00000100", inst_valid, inst_pc, rom_addr);
      end
      tick();
      checks++;
      if (inst_pc !== 32'h100 || inst_o !== rom_word(32'h100) || rom_addr !== 32'h104) begin
         errors++;
         $display("FAIL branch_target: pc=%h inst=%h addr=%h expected 00000100/%h/00000104", inst_pc, inst_o, rom_addr, rom_word(32'h100));
      end
      tick();
      checks++;
      if (inst_pc !== 32'h104 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL branch_after: pc=%h valid=%b expected 00000104/1", inst_pc, inst_valid);
      end
      branch_flag_i = 1'b1; branch_target_i = 32'h203;
      tick();
      checks++;
      if (inst_pc !== 32'h108 || rom_addr !== 32'h200) begin
         errors++;
         $display("FAIL branch_same_cycle: pc=%h addr=%h expected 00000108/00000200", inst_pc, rom_addr);
      end
      branch_flag_i = 1'b0;
      tick();
      checks++;
      if (inst_pc !== 32'h200 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL branch_masked_target: pc=%h valid=%b expected 00000200/1", inst_pc, inst_valid);
      end
   endtask

   task automatic test_flush_branch();
      flush_i = 1'b1; new_pc_i = 32'h180; branch_flag_i = 1'b1; branch_target_i = 32'h300; rom_rdy = 1'b1;
      tick();
      checks++;
      if (inst_valid !== 1'b0 || rom_addr !== 32'h180 || rom_ce !== 1'b1) begin
         errors++;
         $display("FAIL flush_cycle: valid=%b addr=%h ce=%b expected 0/00000180/1", inst_valid, rom_addr, rom_ce);
      end
      flush_i = 1'b0; branch_flag_i = 1'b0;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h180 || inst_o !== rom_word(32'h180) || rom_addr !== 32'h184) begin
         errors++;
         $display("FAIL flush_target: valid=%b pc=%h inst=%h addr=%h expected 1/00000180/%h/00000184", inst_valid, inst_pc, inst_o, rom_addr, rom_word(32'h180));
      end
   endtask

   task automatic test_stall();
      stall_i = 1'b1; rom_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
`ifdef IF_SKID_EN
         if (inst_valid !== 1'b1 || inst_pc !== 32'h180 || inst_o !== rom_word(32'h180) || rom_ce !== 1'b0 || rom_addr !== 32'h188) begin
            errors++;
            $display("FAIL stall_%0d: valid=%b pc=%h inst=%h ce=%b addr=%h expected 1/00000180/%h/0/00000188", i, inst_valid, inst_pc, inst_o, rom_ce, rom_addr, rom_word(32'h180));
         end
`else
         if (inst_valid !== 1'b1 || inst_pc !== 32'h180 || inst_o !== rom_word(32'h180) || rom_ce !== 1'b1 || rom_addr !== 32'h184) begin
            errors++;
            $display("FAIL stall_%0d: valid=%b pc=%h inst=%h ce=%b addr=%h expected 1/00000180/%h/1/00000184", i, inst_valid, inst_pc, inst_o, rom_ce, rom_addr, rom_word(32'h180));
         end
`endif
      end
      stall_i = 1'b0;
      tick();
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== 32'h184 || inst_o !== rom_word(32'h184) || rom_addr !== 32'h188 || rom_ce !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: valid=%b pc=%h inst=%h addr=%h ce=%b expected 1/00000184/%h/00000188/1", inst_valid, inst_pc, inst_o, rom_addr, rom_ce, rom_word(32'h184));
      end
      tick();
      checks++;
      if (inst_pc !== 32'h188 || inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_after: pc=%h valid=%b expected 00000188/1", inst_pc, inst_valid);
      end
   endtask

   task automatic test_wrap();
      flush_i = 1'b1; new_pc_i = 32'hFFFFFFFA;
      tick();
      flush_i = 1'b0;
      tick();
      checks++;
      if (inst_pc !== 32'hFFFFFFF8 || rom_addr !== 32'hFFFFFFFC) begin
         errors++;
         $display("FAIL wrap_f8: pc=%h addr=%h expected fffffff8/fffffffc", inst_pc, rom_addr);
      end
      tick();
      checks++;
      if (inst_pc !== 32'hFFFFFFFC || rom_addr !== 32'h0) begin
         errors++;
         $display("FAIL wrap_fc: pc=%h addr=%h expected fffffffc/00000000", inst_pc, rom_addr);
      end
      tick();
      checks++;
      if (inst_pc !== 32'h0 || inst_o !== rom_word(32'h0) || rom_addr !== 32'h4) begin
         errors++;
         $display("FAIL wrap_zero: pc=%h inst=%h addr=%h expected 00000000/%h/00000004", inst_pc, inst_o, rom_addr, rom_word(32'h0));
      end
   endtask

   task automatic test_reset_mid_wait();
      rom_rdy = 1'b0;
      tick();
      #2 rst = 1'b0;
      #1;
      checks++;
      if (rom_ce !== 1'b0 || inst_valid !== 1'b0 || rom_addr !== RESET_PC || inst_pc !== 32'd0 || inst_o !== 32'd0) begin
         errors++;
         $display("FAIL reset_mid_wait: ce=%b valid=%b addr=%h pc=%h inst=%h expected 0/0/%h/0/0", rom_ce, inst_valid, rom_addr, inst_pc, inst_o, RESET_PC);
      end
   endtask

   task automatic model_reset();
      m_on = 1'b0; m_ce = 1'b0; m_addr = RESET_PC; m_valid = 1'b0; m_inst = 32'd0; m_pc = 32'd0;
      exp_q.delete();
`ifdef IF_SKID_EN
      m_hold = 1'b0; m_hdata = 32'd0; m_hpc = 32'd0;
`endif
   endtask

   // One clock of the fetch rules: flush > start-up > buffered word > stall > accept > wait.
   task automatic model_step();
      logic [31:0] bt;
      bt = {branch_target_i[31:2], 2'b00};
      if (flush_i) begin
         m_addr = {new_pc_i[31:2], 2'b00}; m_valid = 1'b0; m_ce = 1'b1; m_on = 1'b1;
         exp_q.delete();
`ifdef IF_SKID_EN
         m_hold = 1'b0;
`endif
      end else if (!m_on) begin
         m_on = 1'b1; m_ce = 1'b1;
      end
`ifdef IF_SKID_EN
      else if (m_hold) begin
         if (!stall_i) begin
            m_valid = 1'b1; m_inst = m_hdata; m_pc = m_hpc; m_ce = 1'b1; m_hold = 1'b0;
            if (branch_flag_i) m_addr = bt;
         end
      end
`endif
      else if (stall_i) begin
`ifdef IF_SKID_EN
         if (rom_rdy) begin
            m_hdata = rom_word(m_addr); m_hpc = m_addr;
            m_addr = (exp_q.size() != 0) ? exp_q[0] : m_addr + 32'd4;
            exp_q.delete(); m_ce = 1'b0; m_hold = 1'b1;
         end
`endif
      end else if (rom_rdy) begin
         m_valid = 1'b1; m_inst = rom_word(m_addr); m_pc = m_addr;
         if (branch_flag_i) m_addr = bt;
         else if (exp_q.size() != 0) m_addr = exp_q[0];
         else m_addr = m_addr + 32'd4;
         exp_q.delete();
      end else begin
         m_valid = 1'b0;
         if (branch_flag_i) begin
            exp_q.delete();
            exp_q.push_back(bt);
         end
      end
   endtask

   task automatic test_random();
      rst = 1'b0;
      idle_inputs();
      tick();
      model_reset();
      rst = 1'b1;
      for (int i = 0; i < 600; i++) begin
         flush_i         = ($urandom_range(0, 15) == 0);
         new_pc_i        = $urandom;
         stall_i         = ($urandom_range(0, 4) == 0);
         branch_flag_i   = ($urandom_range(0, 5) == 0);
         branch_target_i = $urandom;
         rom_rdy         = ($urandom_range(0, 3) != 0);
         model_step();
         tick();
         checks++;
         if (rom_ce !== m_ce || rom_addr !== m_addr || inst_valid !== m_valid || inst_pc !== m_pc || inst_o !== m_inst) begin
            errors++;
            $display("FAIL random_%0d: ce=%b addr=%h valid=%b pc=%h inst=%h expected %b/%h/%b/%h/%h",
                     i, rom_ce, rom_addr, inst_valid, inst_pc, inst_o, m_ce, m_addr, m_valid, m_pc, m_inst);
         end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_wait_states();
      test_branch_pending();
      test_flush_branch();
      test_stall();
      test_wrap();
      test_reset_mid_wait();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/if_ctrl.md
# if_ctrl

Instruction-fetch controller that sequences the PC and the instruction ROM for the OpenMIPS pipeline. It sits between the pipeline control logic (stall, flush, branch redirect from ID) and the instruction ROM. It generates the ROM chip-enable and address, accepts ROM data through a ready handshake that supports wait states, and delivers one instruction per cycle, with its PC, to the IF/ID register.

## Interface
- RESET_PC, 32'h00000000, first fetch address after reset (bits [1:0] must be 0)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low; clears all state immediately
- stall_i  in  1  hold request from pipeline control; holds the IF/ID outputs
- flush_i  in  1  exception/redirect; highest priority
- new_pc_i  in  32  flush target
- branch_flag_i  in  1  branch taken in ID (MIPS delay-slot semantics)
- branch_target_i  in  32  branch target
- rom_ce  out  1  ROM chip enable (`ChipEnable`/`ChipDisable` levels)
- rom_addr  out  32  ROM fetch address
- rom_rdy  in  1  ROM data valid for the current rom_addr, same cycle
- rom_data  in  32  ROM read data
- inst_valid  out  1  inst_o/inst_pc hold a live instruction
- inst_o  out  32  fetched instruction to IF/ID
- inst_pc  out  32  address of inst_o

## Operation
- Reset values: rom_ce=0, rom_addr=RESET_PC, inst_valid=0, inst_o=0, inst_pc=0, pend_valid=0, state=IDLE.
- States: IDLE, REQ, HOLD. HOLD exists only with IF_SKID_EN.
- IDLE: on the first edge after reset release, set rom_ce=1 and go to REQ. No other action.
- REQ, accept (rom_rdy=1, stall_i=0, flush_i=0):
  - inst_o<=rom_data, inst_pc<=rom_addr, inst_valid<=1.
  - rom_addr<=next, where next is chosen in priority order: branch_target_i if branch_flag_i=1, else pend_target if pend_valid=1 (then clear pend_valid), else rom_addr+4.
- REQ, no rdy, stall_i=0: inst_valid<=0 (bubble). rom_addr is held. A branch_flag_i in this cycle latches pend_target<=branch_target_i and pend_valid<=1.
- stall_i=1 in any state: inst_valid, inst_o and inst_pc are held. branch_flag_i is ignored.
- Flush (any state, any stall): rom_addr<=new_pc_i, inst_valid<=0, pend_valid<=0, rom_ce<=1, state<=REQ. rom_rdy and branch_flag_i in the same cycle are discarded.
- Address arithmetic: 32-bit unsigned. 32'hFFFFFFFC+4 wraps to 32'h00000000. Bits [1:0] of new_pc_i and branch_target_i are forced to 0.
- Simultaneous events: flush beats branch, branch beats pending, pending beats +4. A branch arriving while pend_valid=1 overwrites pend_target.

## Timing
- First fetch: rst released before edge E0. At E0: rom_ce=1, rom_addr=RESET_PC. With rom_rdy tied 1, at E1: inst_valid=1, inst_pc=RESET_PC, rom_addr=RESET_PC+4.
- Throughput: 1 instruction per cycle with a zero-wait ROM. Each ROM wait cycle inserts one bubble.
- Redirect latency: after a flush at edge En, the new_pc_i instruction appears at En+1 at the earliest (zero-wait ROM).
- Branch: the instruction accepted in the same cycle as branch_flag_i is the delay slot. The target is the next fetch.
- Asserting rst mid-access abandons the access immediately. All outputs go to their reset values.

## Configuration
- IF_SKID_EN defined:
  - REQ with rom_rdy=1 and stall_i=1 captures rom_data and rom_addr into a one-entry buffer, sets rom_addr<=next, sets rom_ce<=0, and goes to HOLD.
  - HOLD with stall_i=0: inst_o<=buffer, inst_pc<=buffered address, inst_valid<=1, rom_ce<=1, go to REQ.
  - HOLD with flush: the buffer is dropped and the flush rule applies.
  - Effect: no ROM re-read after a stall.
- IF_SKID_EN undefined:
  - stall_i=1 in REQ ignores rom_rdy. rom_ce stays 1 and rom_addr is held, so the ROM re-delivers the same word after the stall.
  - HOLD is unreachable.

## Test plan
- Reset release with RESET_PC=0 and rom_rdy=1 -> inst_pc sequence 0,4,8,C over 4 cycles, inst_valid=1 from E1 onward.
- rom_rdy low for 2 cycles on address 8 -> two inst_valid=0 bubbles; rom_addr holds 8; no address skipped.
- branch_flag_i with target 0x100, asserted while fetching 0x10 with no rdy -> 0x10 delivered (delay slot), then 0x100, then 0x104.
- flush_i=1 with new_pc_i=0x180 and branch_flag_i=1 in the same cycle -> next inst_pc=0x180, branch discarded.
- stall_i=1 for 3 cycles with rom_rdy=1 -> outputs frozen. With IF_SKID_EN, rom_ce=0 during the stall and the buffered instruction is delivered on release. Without it, rom_addr is held and the word is re-fetched.
- rom_addr=0xFFFFFFFC accepted -> next rom_addr=0x00000000. Asserting rst mid-wait -> rom_ce=0 and inst_valid=0 immediately.
